// File: rtl/uart_boot_loader.sv
// uart_boot_loader: CPU-side consumer of the host boot stream.
// Sends the 0x99 sync byte, takes a 32-bit little-endian byte length and the program
// image, and writes the image into instruction memory as little-endian words. It then
// answers 0xAA, raises boot_done, and from then on queues every received byte in a
// first-word-fall-through input FIFO that the core reads.
// Optional feature macro: LOADER_CHKSUM_EN. When it is defined, the 8-bit sum of all
// program bytes is sent just before 0xAA.
module uart_boot_loader #(
    parameter int IMEM_AW = 15,
    parameter int FIFO_AW = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_ferr,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               boot_done,
    input  logic               in_rd,
    output logic [7:0]         in_data,
    output logic               in_empty,
    output logic [2:0]         err
);

    localparam logic [7:0]       SYNC_BYTE  = 8'h99;
    localparam logic [7:0]       ACK_BYTE   = 8'hAA;
    localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        SEND_SYNC,
        LEN,
        PROG,
        SEND_ACK,
        RUN
    } state_t;

    state_t state, state_next;

    logic [31:0]      len;
    logic [31:0]      len_full;
    logic [31:0]      byte_cnt;
    logic [31:0]      wbuf;
    logic [31:0]      asm_word;
    logic [IMEM_AW:0] wcnt;        // next word index; the top bit marks imem exhausted
    logic             tx_launch;
    logic [7:0]       tx_byte;
    logic             len_byte;
    logic             prog_byte;
    logic             prog_last;
    logic             fifo_push;
    logic             enter_run;
    logic             err_fifo;
    logic             err_prog;
    logic             err_rx;

`ifdef LOADER_CHKSUM_EN
    logic [7:0] sum;
    logic       ack_phase;         // 0: checksum byte pending, 1: 0xAA pending
`endif

    assign err       = {err_fifo, err_prog, err_rx};
    // The length is complete once the byte now arriving lands in bits [31:24].
    assign len_full  = {rx_data, len[23:0]};
    assign prog_last = (byte_cnt[1:0] == 2'd3) || (byte_cnt + 32'd1 == len);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments, so every register samples
        // the values from before the edge, whatever order the statements are written in.
        if (rst) begin
            state <= SEND_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that left one
        // unassigned would make it hold its old value, and that infers a latch.
        state_next = state;
        tx_launch  = 1'b0;
        tx_byte    = SYNC_BYTE;
        len_byte   = 1'b0;
        prog_byte  = 1'b0;
        fifo_push  = 1'b0;
        enter_run  = 1'b0;
        case (state)
            SEND_SYNC: begin
                if (tx_start) begin
                    if (tx_busy) begin
                        state_next = LEN;
                    end
                end else if (!tx_busy) begin
                    tx_launch = 1'b1;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    len_byte = 1'b1;
                    if (byte_cnt[1:0] == 2'd3) begin
                        state_next = (len_full == 32'd0) ? SEND_ACK : PROG;
                    end
                end
            end
            PROG: begin
                if (rx_valid) begin
                    prog_byte = 1'b1;
                    if (byte_cnt + 32'd1 == len) begin
                        state_next = SEND_ACK;
                    end
                end
            end
            SEND_ACK: begin
`ifdef LOADER_CHKSUM_EN
                tx_byte = ack_phase ? ACK_BYTE : sum;
                if (tx_start) begin
                    if (tx_busy && ack_phase) begin
                        state_next = RUN;
                        enter_run  = 1'b1;
                    end
                end else if (!tx_busy) begin
                    tx_launch = 1'b1;
                end
`else
                tx_byte = ACK_BYTE;
                if (tx_start) begin
                    if (tx_busy) begin
                        state_next = RUN;
                        enter_run  = 1'b1;
                    end
                end else if (!tx_busy) begin
                    tx_launch = 1'b1;
                end
`endif
            end
            RUN: begin
                fifo_push = rx_valid;
            end
            default: begin
                state_next = SEND_SYNC;
            end
        endcase
    end

    // Merge the incoming byte into its lane. Lane 0 starts a fresh word, so any upper
    // lanes never filled by a short final word read as zero.
    always_comb begin
        asm_word = (byte_cnt[1:0] == 2'd0) ? 32'h0 : wbuf;
        case (byte_cnt[1:0])
            2'd0:    asm_word[7:0]   = rx_data;
            2'd1:    asm_word[15:8]  = rx_data;
            2'd2:    asm_word[23:16] = rx_data;
            default: asm_word[31:24] = rx_data;
        endcase
    end

    // Loader datapath: TX handshake, length capture, word assembly, imem writes, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            len        <= 32'd0;
            byte_cnt   <= 32'd0;
            wbuf       <= 32'd0;
            wcnt       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            boot_done  <= 1'b0;
            err_prog   <= 1'b0;
            err_rx     <= 1'b0;
        end else begin
            // Hold the request until the transmitter shows busy, then drop it on that edge.
            if (tx_launch) begin
                tx_start <= 1'b1;
                tx_data  <= tx_byte;
            end else if (tx_start && tx_busy) begin
                tx_start <= 1'b0;
            end

            // A framing error is recorded, but the byte itself is still used.
            if (rx_valid && rx_ferr) begin
                err_rx <= 1'b1;
            end

            if (len_byte) begin
                case (byte_cnt[1:0])
                    2'd0:    len[7:0]   <= rx_data;
                    2'd1:    len[15:8]  <= rx_data;
                    2'd2:    len[23:16] <= rx_data;
                    default: len[31:24] <= rx_data;
                endcase
                byte_cnt <= (byte_cnt[1:0] == 2'd3) ? 32'd0 : byte_cnt + 32'd1;
            end

            // The write strobe lasts one cycle, and the address steps past the word just written.
            imem_we <= 1'b0;
            if (imem_we) begin
                imem_addr <= imem_addr + IMEM_AW'(1);
            end

            if (prog_byte) begin
                byte_cnt <= byte_cnt + 32'd1;
                wbuf     <= asm_word;
                if (prog_last) begin
                    // Words past the end of imem are dropped, but their bytes still count.
                    if (wcnt[IMEM_AW]) begin
                        err_prog <= 1'b1;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_wdata <= asm_word;
                        imem_addr  <= wcnt[IMEM_AW-1:0];
                        wcnt       <= wcnt + (IMEM_AW+1)'(1);
                    end
                end
            end

            if (enter_run) begin
                boot_done <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHKSUM_EN
    // Running sum of the program bytes, and the tracker for which acknowledge byte is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= 8'h00;
            ack_phase <= 1'b0;
        end else begin
            if (prog_byte) begin
                sum <= sum + rx_data;
            end
            if (state == SEND_ACK && tx_start && tx_busy) begin
                ack_phase <= 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------ input FIFO
    logic [7:0]         fifo_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW-1:0] rptr_n;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_after_pop;
    logic [FIFO_AW:0]   count_n;
    logic               pop;
    logic               push_ok;

    // FIFO occupancy bookkeeping. When the FIFO is full, a push in the same cycle as a pop is accepted.
    always_comb begin
        pop             = in_rd && !in_empty;
        push_ok         = fifo_push && ((count != FIFO_DEPTH) || pop);
        rptr_n          = pop ? rptr + FIFO_AW'(1) : rptr;
        count_after_pop = pop ? count - (FIFO_AW+1)'(1) : count;
        count_n         = push_ok ? count_after_pop + (FIFO_AW+1)'(1) : count_after_pop;
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The pointers and count define which
        // entries are valid, and leaving the array unreset lets it map onto RAM.
        if (push_ok) begin
            fifo_mem[wptr] <= rx_data;
        end
    end

    // FIFO pointers, registered head byte, empty flag and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            in_data  <= 8'h00;
            in_empty <= 1'b1;
            err_fifo <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + FIFO_AW'(1);
            end
            rptr     <= rptr_n;
            count    <= count_n;
            in_empty <= (count_n == '0);
            // A byte pushed into an empty FIFO bypasses the array and becomes the head directly.
            if (push_ok && count_after_pop == '0) begin
                in_data <= rx_data;
            end else if (count_after_pop != '0) begin
                in_data <= fifo_mem[rptr_n];
            end
            if (fifo_push && !push_ok) begin
                err_fifo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader. A small model of the transmitter echoes
// tx_busy and logs each byte sent. A monitor logs each instruction-memory write.
// The expected values are written out by hand for each step.
module tb_uart_boot_loader;

    localparam int IMEM_AW = 3;
    localparam int FIFO_AW = 9;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               rx_ferr = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy = 1'b0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               boot_done;
    logic               in_rd = 1'b0;
    logic [7:0]         in_data;
    logic               in_empty;
    logic [2:0]         err;

    int vectors = 0;
    int fails   = 0;
    int busy_cnt = 0;

    logic [7:0]         tx_log[$];
    logic [IMEM_AW-1:0] wa_log[$];
    logic [31:0]        wd_log[$];
    logic [7:0]         prog[$];

    uart_boot_loader #(.IMEM_AW(IMEM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ferr    (rx_ferr),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .boot_done  (boot_done),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_empty   (in_empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Transmitter model: accept a request, log the byte, stay busy for four cycles.
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (tx_start && !tx_busy) begin
            tx_log.push_back(tx_data);
            tx_busy  = 1'b1;
            busy_cnt = 4;
        end
    end

    // Instruction-memory write monitor.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_log.push_back(imem_addr);
            wd_log.push_back(imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        if (i < tx_log.size()) return {24'h0, tx_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wa_at(input int i);
        if (i < wa_log.size()) return 32'(wa_log[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        if (i < wd_log.size()) return wd_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        in_rd    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, ":rst_tx_start"},  32'(tx_start),  32'd0);
        check({tag, ":rst_tx_data"},   32'(tx_data),   32'd0);
        check({tag, ":rst_imem_we"},   32'(imem_we),   32'd0);
        check({tag, ":rst_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, ":rst_imem_wdata"}, imem_wdata,    32'd0);
        check({tag, ":rst_boot_done"}, 32'(boot_done), 32'd0);
        check({tag, ":rst_in_empty"},  32'(in_empty),  32'd1);
        check({tag, ":rst_in_data"},   32'(in_data),   32'd0);
        check({tag, ":rst_err"},       32'(err),       32'd0);
        tx_log.delete();
        wa_log.delete();
        wd_log.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit ferr);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_ferr  = ferr;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        for (int t = 0; t < 1000 && tx_log.size() < n; t++) @(posedge clk);
        #1;
        check({tag, ":tx_count"}, 32'(tx_log.size()), 32'(n));
    endtask

    task automatic wait_boot(input string tag);
        for (int t = 0; t < 1000 && !boot_done; t++) @(posedge clk);
        #1;
        check({tag, ":boot_done"}, 32'(boot_done), 32'd1);
    endtask

    // Full boot: sync byte, length, program, then check the acknowledge bytes.
    task automatic load(input string tag, input logic [31:0] n, input int ferr_idx,
                        input logic [7:0] exp_sum);
        wait_tx({tag, ":sync"}, 1);
        check({tag, ":sync_byte"}, tx_at(0), 32'h99);
        for (int i = 0; i < 4; i++) send_rx(n[8*i +: 8], 1'b0);
        for (int i = 0; i < prog.size(); i++) send_rx(prog[i], i == ferr_idx);
        wait_boot(tag);
`ifdef LOADER_CHKSUM_EN
        check({tag, ":ack_count"}, 32'(tx_log.size()), 32'd3);
        check({tag, ":chksum"}, tx_at(1), {24'h0, exp_sum});
        check({tag, ":ack"}, tx_at(2), 32'hAA);
`else
        check({tag, ":ack_count"}, 32'(tx_log.size()), 32'd2);
        check({tag, ":ack"}, tx_at(1), 32'hAA);
        check({tag, ":sum_unused"}, 32'(exp_sum) & 32'h0, 32'h0 & 32'(tx_log.size()));
`endif
    endtask

    initial begin
        // 1: reset and the first sync request
        do_reset("t1");
        @(posedge clk); #1;
        check("t1:tx_start_req", 32'(tx_start), 32'd1);
        check("t1:tx_data_sync", 32'(tx_data),  32'h99);
        check("t1:busy_low",     32'(tx_busy),  32'd0);
        @(posedge clk); #1;
        check("t1:tx_start_drop", 32'(tx_start),  32'd0);
        check("t1:boot_done_lo",  32'(boot_done), 32'd0);

        // 2: eight bytes, two full words
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load("t2", 32'd8, -1, 8'h18);
        check("t2:wr_count", 32'(wa_log.size()), 32'd2);
        check("t2:addr0", wa_at(0), 32'd0);
        check("t2:data0", wd_at(0), 32'h04030201);
        check("t2:addr1", wa_at(1), 32'd1);
        check("t2:data1", wd_at(1), 32'hDDCCBBAA);
        check("t2:err",   32'(err), 32'd0);

        // 3: six bytes, the final word is partial
        do_reset("t3");
        prog = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        load("t3", 32'd6, -1, 8'h75);
        check("t3:wr_count", 32'(wa_log.size()), 32'd2);
        check("t3:data0", wd_at(0), 32'h14131211);
        check("t3:addr1", wa_at(1), 32'd1);
        check("t3:data1", wd_at(1), 32'h00001615);

        // 4: zero length, acknowledge right after the length bytes
        do_reset("t4");
        prog.delete();
        load("t4", 32'd0, -1, 8'h00);
        check("t4:wr_count", 32'(wa_log.size()), 32'd0);

        // 5: input FIFO in RUN
        @(negedge clk);
        in_rd = 1'b1;
        repeat (2) @(negedge clk);
        in_rd = 1'b0;
        check("t5:empty_rd_ignored", 32'(in_empty), 32'd1);
        check("t5:empty_rd_no_err",  32'(err),      32'd0);

        @(negedge clk);
        rx_data  = 8'h42;
        rx_valid = 1'b1;
        #1;
        check("t5:empty_same_cycle", 32'(in_empty), 32'd1);
        @(posedge clk); #1;
        check("t5:empty_fell", 32'(in_empty), 32'd0);
        check("t5:head_42",    32'(in_data),  32'h42);
        @(negedge clk);
        rx_valid = 1'b0;
        in_rd    = 1'b1;
        @(negedge clk);
        in_rd = 1'b0;
        check("t5:single_popped", 32'(in_empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            rx_data  = 8'(i);
            rx_valid = 1'b1;
        end
        @(negedge clk);
        check("t5:full_head", 32'(in_data), 32'h00);
        check("t5:full_err",  32'(err),     32'd0);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        in_rd    = 1'b1;
        @(negedge clk);
        in_rd = 1'b0;
        check("t5:pushpop_no_ovf", 32'(err),     32'd0);
        check("t5:pushpop_head",   32'(in_data), 32'h01);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("t5:overflow_err", 32'(err), 32'b100);

        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check($sformatf("t5:pop%0d", k), 32'(in_data),
                  (k < DEPTH - 1) ? 32'((k + 1) & 8'hFF) : 32'hEE);
            in_rd = 1'b1;
        end
        @(negedge clk);
        in_rd = 1'b0;
        check("t5:drained", 32'(in_empty), 32'd1);

        send_rx(8'h5C, 1'b1);
        check("t5:ferr_byte_kept", 32'(in_data),  32'h5C);
        check("t5:ferr_not_empty", 32'(in_empty), 32'd0);
        check("t5:ferr_err",       32'(err),      32'b101);

        // 6: reset in the middle of a load, then a clean reload
        do_reset("t6a");
        wait_tx("t6a:sync", 1);
        send_rx(8'h08, 1'b0);
        send_rx(8'h00, 1'b0);
        send_rx(8'h00, 1'b0);
        send_rx(8'h00, 1'b0);
        send_rx(8'h21, 1'b0);
        send_rx(8'h22, 1'b0);
        send_rx(8'h23, 1'b0);
        do_reset("t6b");
        prog = '{8'h31, 8'h32, 8'h33, 8'h34};
        load("t6", 32'd4, -1, 8'hCA);
        check("t6:wr_count", 32'(wa_log.size()), 32'd1);
        check("t6:addr0",    wa_at(0), 32'd0);
        check("t6:data0",    wd_at(0), 32'h34333231);

        // 7: program larger than imem (8 words), with one framing error
        do_reset("t7");
        prog.delete();
        for (int i = 0; i < 36; i++) prog.push_back(8'(i));
        load("t7", 32'd36, 5, 8'h76);
        check("t7:wr_count", 32'(wa_log.size()), 32'd8);
        check("t7:data0",    wd_at(0), 32'h03020100);
        check("t7:data1",    wd_at(1), 32'h07060504);
        check("t7:addr7",    wa_at(7), 32'd7);
        check("t7:data7",    wd_at(7), 32'h1F1E1D1C);
        check("t7:err",      32'(err), 32'b011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
